// File: rtl/main_memory_backend_if.sv
// Cache-miss interface between the data-cache controller (master) and the
// backing store (slave). The request is held by the master until mem_ready.
interface main_memory_backend_if #(
  parameter int BLOCK_WORDS = 4
);
  logic                      mem_read;
  logic                      mem_write;
  logic [31:0]               mem_addr;
  logic [32*BLOCK_WORDS-1:0] mem_wdata;
  logic [32*BLOCK_WORDS-1:0] mem_rdata;
  logic                      mem_ready;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/main_memory_backend.sv
// Multi-cycle block backing store. It captures one refill or write-back
// request in IDLE, spends LATENCY cycles in BUSY, then pulses mem_ready for
// one cycle in DONE. Reads load mem_rdata and writes commit storage on the
// edge that leaves BUSY.
module main_memory_backend #(
  parameter int ADDR_WIDTH  = 10,
  parameter int BLOCK_WORDS = 4,
  parameter int LATENCY     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  main_memory_backend_if.slave  mem_if
);

  localparam int AW    = ADDR_WIDTH;
  localparam int BW    = 32 * BLOCK_WORDS;
  localparam int CW    = $clog2(LATENCY + 1);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            op_write_q;
  logic [AW-1:0]   addr_q;
  logic [BW-1:0]   wdata_q;
  logic [BW-1:0]   rdata_q;
  logic            ready_q;

  logic [31:0]     mem_q [DEPTH];

  logic [AW-1:0]   word_addr;
  logic [BW-1:0]   rd_block;
  logic            commit_we;
  logic            unused_addr_bits;

  // Block-aligned word address; bits above the storage range wrap away.
  assign word_addr = mem_if.mem_addr[AW+1:2] & ~AW'(BLOCK_WORDS - 1);

  // Byte-offset bits and bits beyond capacity are deliberately ignored.
  assign unused_addr_bits = &{1'b0, mem_if.mem_addr[31:AW+2], mem_if.mem_addr[1:0]};

  // Storage commit happens on the final BUSY edge of a write.
  assign commit_we = (state_q == BUSY) && (cnt_q == '0) && op_write_q;

  // Gather the captured block from storage for the read completion.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rd_block = '0;
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      rd_block[32*i +: 32] = mem_q[addr_q + AW'(i)];
    end
  end

  // Transaction FSM with registered completion outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees the pre-edge values of its neighbours.
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          if (mem_if.mem_read || mem_if.mem_write) begin
            // A simultaneous read and write is treated as a write.
            op_write_q <= mem_if.mem_write;
            addr_q     <= word_addr;
            if (mem_if.mem_write) begin
              wdata_q <= mem_if.mem_wdata;
            end
            cnt_q   <= CW'(LATENCY - 1);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
            ready_q <= 1'b1;
            if (!op_write_q) begin
              rdata_q <= rd_block;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Block write into storage; the async reset forces IDLE, so a write
  // interrupted by reset never reaches this enable.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is intentionally not reset; its contents survive rst.
    if (commit_we) begin
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        mem_q[addr_q + AW'(i)] <= wdata_q[32*i +: 32];
      end
    end
  end

  assign mem_if.mem_rdata = rdata_q;
  assign mem_if.mem_ready = ready_q;

endmodule

// File: doc/main_memory_backend.md
# main_memory_backend

Multi-cycle backing store behind the data cache. It answers block refill (read) and block write-back (write) requests from the cache controller. Every transaction returns a one-cycle `mem_ready` completion pulse after a fixed, parameterised latency. It is the responder end of the cache-miss interface: the cache raises its stall while a transaction is outstanding and releases it on `mem_ready`.

## Interface
- `ADDR_WIDTH`, 10: word-address bits of storage; capacity is 2^ADDR_WIDTH 32-bit words.
- `BLOCK_WORDS`, 4: words per cache block; power of two, ≥1.
- `LATENCY`, 4: cycles spent in BUSY per transaction; ≥1.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_read` in 1: block read request.
- `mem_write` in 1: block write request.
- `mem_addr` in 32: byte address. Low log2(BLOCK_WORDS)+2 bits are ignored, so the address is block-aligned.
- `mem_wdata` in 32·BLOCK_WORDS: write block. Word i sits in bits [32i+31:32i].
- `mem_rdata` out 32·BLOCK_WORDS: read block, same packing as `mem_wdata`.
- `mem_ready` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - If `mem_read` or `mem_write` is high at a rising edge, capture the address, the op, and `mem_wdata` (for writes) into internal registers.
  - Load the counter with LATENCY-1 and go to BUSY.
  - If both request lines are high, the transaction is a write. `mem_rdata` is not updated.
- BUSY:
  - Request inputs are ignored; the captured values are used.
  - The counter decrements each edge.
  - On the edge where the counter is 0, go to DONE and set `mem_ready`.
  - On that same edge, a read loads `mem_rdata` from the captured block. A write commits all BLOCK_WORDS words to storage.
- DONE: `mem_ready` is high for exactly this one cycle. The next edge returns to IDLE and clears `mem_ready`. Requests present during DONE are ignored.
- Protocol: the requester holds its request stable until it sees `mem_ready`, then deasserts it at the next edge. A request still high in IDLE after DONE is treated as a new transaction.
- Address mapping:
  - Block base word = `mem_addr`[ADDR_WIDTH+1 : log2(BLOCK_WORDS)+2] × BLOCK_WORDS.
  - Address bits above ADDR_WIDTH+1 are ignored, so accesses wrap modulo capacity.
- Counter width is $clog2(LATENCY+1). LATENCY=1 means one BUSY cycle.

## Timing
- Reset values: state IDLE; `mem_ready` 0; `mem_rdata` all zeros; counter 0.
- Storage contents are not cleared by reset and survive it.
- Let E0 be the edge that samples the request in IDLE.
- BUSY occupies the cycles after E0 through edge E0+LATENCY.
- `mem_ready` and valid `mem_rdata` appear after edge E0+LATENCY. `mem_ready` falls after E0+LATENCY+1.
- Write data is visible to a subsequent read from the cycle after E0+LATENCY.
- `mem_rdata` holds its value until the next completed read or a reset.
- Minimum request-to-request spacing is LATENCY+2 edges: IDLE, then LATENCY BUSY cycles, then DONE.
- Reset asserted mid-transaction:
  - Immediate return to IDLE, with `mem_ready`=0 and `mem_rdata`=0.
  - A pending write is discarded and storage is unchanged.
  - A request held high after reset release is sampled as a fresh transaction.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset values:** Hold `rst`=1 for 2 cycles, then release with no request. Required: `mem_ready`=0 and `mem_rdata`=0 throughout; `mem_ready` never pulses.
- **Write then read back:** Write `mem_addr`=0x40 with `mem_wdata`={0x44444444,0x33333333,0x22222222,0x11111111}; `mem_ready` pulses exactly 1 cycle, 4 edges after the sampling edge. Then read 0x4C. Required: `mem_rdata` equals the same 128-bit block (low bits ignored), with `mem_ready` 4 edges after sampling.
- **Simultaneous read and write:** Assert both with `mem_addr`=0x80, data 0xA5A5… Required: the write is performed, `mem_rdata` retains its prior value, and a following read of 0x80 returns 0xA5A5….
- **Reset mid-write:** Start a write of 0xDEADBEEF×4 to 0x100 and pulse `rst` two cycles into BUSY. Required: `mem_ready` never pulses and `mem_rdata`=0. A read of 0x100 then returns the pre-existing contents, not 0xDEADBEEF.
- **Held request and input changes during BUSY:** Keep `mem_read`=1 continuously at 0x40. Required: `mem_ready` pulses every 6 cycles (LATENCY+2). Changing `mem_addr` to 0xC0 during BUSY does not change the returned block.
- **Address wrap:** With ADDR_WIDTH=10, write to 0x1040 and read 0x0040. Required: the data matches, showing the 4 KiB wrap.
